multicycle_alu: RTL and testbench
=================================

MULTICYCLE_ALU -- requirements
Module: Multicycle_ALU

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 ALU_control  input  3  operation code from the ALU decoder.
REQ-007 src_a  input  32  operand A.
REQ-008 src_b  input  32  operand B; for shifts, the amount is src_b[4:0].
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  32  operation result.
REQ-012 zero  output  1  result equals 0.
REQ-013 err  output  1  illegal ALU_control was accepted.

Function
REQ-014 Encoding SHALL be:
  - 000 add
  - 001 sub
  - 010 and
  - 011 or
  - 100 sll
  - 101 slt (signed; result 1 or 0)
  - 110 srl (logical)
  - 111 illegal
REQ-015 States SHALL be IDLE, SHIFT and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-018 ALU_control, src_a and src_b SHALL be captured at acceptance; later changes SHALL be ignored.
REQ-019 On accepting add/sub/and/or/slt/illegal, the block SHALL compute the result in the accept cycle and go to DONE, so out_valid=1 one cycle after acceptance.
REQ-020 Add/sub SHALL wrap modulo 2^32 with no overflow flag.
REQ-021 On accepting sll/srl with amount k:
  - k=0: result SHALL be src_a, going directly to DONE (latency 1).
  - k>0: the block SHALL load src_a and counter=k, then enter SHIFT.
REQ-022 In SHIFT, each cycle SHALL shift the working register by exactly one bit and decrement the counter.
  - Zero-fill in both directions.
  - Transition to DONE on the cycle the counter reaches 0.
  - Total latency k+1 cycles from acceptance; k=31 gives 32 cycles.
REQ-023 In DONE:
  - out_valid=1.
  - result, zero and err SHALL be held stable until out_ready=1.
REQ-024 On an edge with out_valid=1 and out_ready=1, the block SHALL go to IDLE.
  - out_valid drops to 0 and in_ready rises to 1 on the next cycle.
  - There is no accept-while-done bypass.
REQ-025 out_ready SHALL be ignored outside DONE, and in_valid SHALL be ignored outside IDLE.
REQ-026 zero SHALL equal (result==0) whenever out_valid=1.
REQ-027 An illegal code (111) SHALL produce result=0, zero=1, err=1 with latency 1.
  - err SHALL be 0 for all legal codes.
REQ-028 result, zero and err are don't-care while out_valid=0 but SHALL NOT glitch while out_valid=1.

Reset
REQ-029 While rst_n=0, the block SHALL force:
  - state=IDLE, counter=0
  - in_ready=1, out_valid=0
  - result=0, zero=0, err=0
REQ-030 Reset asserted mid-SHIFT or in DONE SHALL abort the operation immediately and asynchronously; the pending result SHALL be discarded.
REQ-031 After rst_n deasserts, the first rising edge SHALL be able to accept a request.

Verification
REQ-032 Add: src_a=0x7FFFFFFF, src_b=1, code 000 -> one cycle later out_valid=1, result=0x80000000, zero=0.
REQ-033 Sub then slt:
  - Sub: src_a=5, src_b=5, code 001 -> result=0, zero=1.
  - slt: src_a=0xFFFFFFFF, src_b=1, code 101 -> result=1.
REQ-034 Shifts:
  - sll: src_a=1, src_b=31 -> out_valid exactly 32 cycles after accept, result=0x80000000, in_ready=0 throughout.
  - srl: src_a=0x80000000, src_b=0x24 (k=4) -> 5 cycles, result=0x08000000.
REQ-035 Backpressure: hold out_ready=0 for 10 cycles after a result -> out_valid and result stable, in_ready=0, new in_valid ignored; release -> IDLE next cycle.
REQ-036 Illegal/reset:
  - Code 111 -> result=0, err=1.
  - rst_n pulsed low at cycle 3 of an sll by 20 -> out_valid=0 and in_ready=1 immediately; no stale result afterward.

Source files
------------

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle add/sub/and/or/slt, bit-serial sll/srl,
// valid/ready handshake on both request and result sides.
module multicycle_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  ALU_control,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero,
  output logic        err
);

  localparam int unsigned DW  = 32;
  localparam int unsigned CW  = 5;
  localparam int unsigned OPW = 3;

  localparam logic [OPW-1:0] OP_ADD = 3'b000;
  localparam logic [OPW-1:0] OP_SUB = 3'b001;
  localparam logic [OPW-1:0] OP_AND = 3'b010;
  localparam logic [OPW-1:0] OP_OR  = 3'b011;
  localparam logic [OPW-1:0] OP_SLL = 3'b100;
  localparam logic [OPW-1:0] OP_SLT = 3'b101;
  localparam logic [OPW-1:0] OP_SRL = 3'b110;
  localparam logic [OPW-1:0] OP_ILL = 3'b111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            dir_srl;
  logic [DW-1:0]   alu_c;
  logic [DW-1:0]   shift_next_c;
  logic [CW-1:0]   shamt_c;

  assign shamt_c = src_b[CW-1:0];

  // Single-cycle operations, evaluated on the live inputs at acceptance
  always_comb begin
    alu_c = '0;
    case (ALU_control)
      OP_ADD:  alu_c = src_a + src_b;
      OP_SUB:  alu_c = src_a - src_b;
      OP_AND:  alu_c = src_a & src_b;
      OP_OR:   alu_c = src_a | src_b;
      OP_SLT:  alu_c = DW'($signed(src_a) < $signed(src_b));
      default: alu_c = '0;
    endcase
  end

  // result doubles as the shift working register while out_valid is low
  assign shift_next_c = dir_srl ? (result >> 1) : (result << 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      dir_srl   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            err      <= 1'b0;
            if (ALU_control == OP_SLL || ALU_control == OP_SRL) begin
              dir_srl <= (ALU_control == OP_SRL);
              result  <= src_a;
              if (shamt_c == '0) begin
                zero      <= (src_a == '0);
                out_valid <= 1'b1;
                state     <= DONE;
              end else begin
                cnt   <= shamt_c;
                state <= SHIFT;
              end
            end else if (ALU_control == OP_ILL) begin
              result    <= '0;
              zero      <= 1'b1;
              err       <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              result    <= alu_c;
              zero      <= (alu_c == '0);
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        SHIFT: begin
          result <= shift_next_c;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            zero      <= (shift_next_c == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed-vector bench for multicycle_alu: table of operations plus
// backpressure and mid-shift reset sequences.
module tb_multicycle_alu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ALU_control;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;

  multicycle_alu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ALU_control (ALU_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_zero;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Issue one request, scramble inputs after acceptance, measure latency,
  // check the result, then drain it with out_ready.
  task automatic run_op(input vec_t v);
    int   lat;
    logic rdy_bad;
    @(negedge clk);
    in_valid    = 1'b1;
    ALU_control = v.op;
    src_a       = v.a;
    src_b       = v.b;
    chk({v.name, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid    = 1'b0;
    ALU_control = 3'b010;
    src_a       = 32'hDEAD_BEEF;
    src_b       = 32'h1234_5677;
    lat     = 1;
    rdy_bad = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk({v.name, "_latency"}, 32'(lat), 32'(v.exp_lat));
    chk({v.name, "_result"}, result, v.exp_res);
    chk({v.name, "_zero"}, 32'(zero), 32'(v.exp_zero));
    chk({v.name, "_err"}, 32'(err), 32'(v.exp_err));
    chk({v.name, "_busy"}, 32'(rdy_bad | in_ready), 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({v.name, "_drain"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  vec_t vecs[13];
  vec_t bp;
  vec_t post;

  initial begin
    vecs[0]  = '{"add_ovf",  3'b000, 32'h7FFF_FFFF, 32'h1,  32'h8000_0000, 1'b0, 1'b0, 1};
    vecs[1]  = '{"add_wrap", 3'b000, 32'hFFFF_FFFF, 32'h1,  32'h0,         1'b1, 1'b0, 1};
    vecs[2]  = '{"sub_eq",   3'b001, 32'h5,         32'h5,  32'h0,         1'b1, 1'b0, 1};
    vecs[3]  = '{"sub_neg",  3'b001, 32'h0,         32'h1,  32'hFFFF_FFFF, 1'b0, 1'b0, 1};
    vecs[4]  = '{"and",      3'b010, 32'hF0F0_1234, 32'hFF00_FF0F, 32'hF000_1204, 1'b0, 1'b0, 1};
    vecs[5]  = '{"or",       3'b011, 32'h0000_00A0, 32'h0500_000A, 32'h0500_00AA, 1'b0, 1'b0, 1};
    vecs[6]  = '{"slt_neg",  3'b101, 32'hFFFF_FFFF, 32'h1,  32'h1,         1'b0, 1'b0, 1};
    vecs[7]  = '{"slt_pos",  3'b101, 32'h1, 32'hFFFF_FFFF,  32'h0,         1'b1, 1'b0, 1};
    vecs[8]  = '{"sll31",    3'b100, 32'h1,         32'd31, 32'h8000_0000, 1'b0, 1'b0, 32};
    vecs[9]  = '{"srl4",     3'b110, 32'h8000_0000, 32'h24, 32'h0800_0000, 1'b0, 1'b0, 5};
    vecs[10] = '{"srl_k0",   3'b110, 32'hCAFE_F00D, 32'h20, 32'hCAFE_F00D, 1'b0, 1'b0, 1};
    vecs[11] = '{"sll_out",  3'b100, 32'hC000_0000, 32'd2,  32'h0,         1'b1, 1'b0, 3};
    vecs[12] = '{"illegal",  3'b111, 32'h1234_5678, 32'h9,  32'h0,         1'b1, 1'b1, 1};

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    ALU_control = 3'b000;
    src_a       = '0;
    src_b       = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ports", {27'd0, in_ready, out_valid, zero, err, 1'b0}, 32'b10000);
    chk("rst_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_op(vecs[i]);

    // Backpressure: result held for 10 cycles while a new request is offered
    begin
      logic stable;
      bp = '{"bp", 3'b000, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0, 1};
      @(negedge clk);
      in_valid = 1'b1; ALU_control = bp.op; src_a = bp.a; src_b = bp.b;
      @(posedge clk); #1;
      ALU_control = 3'b001; src_a = 32'd7; src_b = 32'd9;
      stable = 1'b1;
      for (int c = 0; c < 10; c++) begin
        if (!(out_valid === 1'b1 && result === 32'd123 && zero === 1'b0 &&
              err === 1'b0 && in_ready === 1'b0)) stable = 1'b0;
        @(posedge clk); #1;
      end
      chk("bp_stable", 32'(stable), 32'd1);
      chk("bp_result", result, 32'd123);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_release", {30'd0, out_valid, in_ready}, 32'b01);
    end

    // Reset during the third cycle of an sll by 20 aborts immediately
    begin
      logic stale;
      @(negedge clk);
      in_valid = 1'b1; ALU_control = 3'b100; src_a = 32'h1; src_b = 32'd20;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_abort_ports", {30'd0, out_valid, in_ready}, 32'b01);
      chk("rst_abort_result", result, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      stale = 1'b0;
      for (int c = 0; c < 25; c++) begin
        @(posedge clk); #1;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) stale = 1'b1;
      end
      chk("rst_no_stale", 32'(stale), 32'd0);
    end

    post = '{"post_rst", 3'b001, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0, 1};
    run_op(post);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
